// File: rtl/conv_ctrl_pkg.sv
// Shared types and constants for the kernel-weight sequencer: state encoding,
// bank geometry and the bank start-address helper.
package conv_ctrl_pkg;
    localparam int KW_ADDR_W = 7;
    localparam int KW_PASS_W = 4;
    localparam int WPK       = 8;
    localparam int IDX_W     = 3;
    localparam int BANK_BASE = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Address 0 is reserved, so bank F occupies 8*F+1 .. 8*F+8.
    function automatic logic [KW_ADDR_W-1:0] kw_start(input logic [2:0] f);
        return KW_ADDR_W'(WPK * int'(f) + BANK_BASE);
    endfunction
endpackage

// File: rtl/conv_kw_sequencer_addr_gen.sv
// Kernel-bank address counter: loads the bank start address, steps one word
// per cycle and flags the last word of the bank.
module kw_addr_gen
    import conv_ctrl_pkg::*;
#(
    parameter int ADDR_W = KW_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output logic              last
);
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    always_comb begin
        addr_d = addr_q;
        idx_d  = idx_q;
        if (load) begin
            addr_d = load_addr;
            idx_d  = '0;
        end else if (inc) begin
            addr_d = addr_q + ADDR_W'(1);
            idx_d  = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            idx_q  <= '0;
        end else begin
            addr_q <= addr_d;
            idx_q  <= idx_d;
        end
    end

    assign addr = addr_q;
    assign idx  = idx_q;
    assign last = (idx_q == IDX_W'(WPK - 1));
endmodule

// File: rtl/conv_kw_sequencer.sv
// Layer controller: loads one kernel bank from the weight ROM, then runs the
// requested conv passes. KW_ROM_REG_EN selects a registered ROM (2-cycle read).
module conv_kw_sequencer
    import conv_ctrl_pkg::*;
#(
    parameter int ADDR_W = KW_ADDR_W,
    parameter int PASS_W = KW_PASS_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_f,
    input  logic [PASS_W-1:0] cfg_passes,
    input  logic              abort,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              w_wr_en,
    output logic [IDX_W-1:0]  w_wr_idx,
    output logic              conv_start,
    input  logic              conv_done,
    output logic              layer_done,
    output logic              busy,
    output state_t            dbg_state
);
    state_t            state_q, state_d;
    logic [PASS_W-1:0] passes_q, passes_d;
    logic              ag_load, ag_inc, ag_last;
    logic [ADDR_W-1:0] ag_addr;
    logic [IDX_W-1:0]  ag_idx;
    logic              en1_q, en1_d;
    logic [IDX_W-1:0]  idx1_q, idx1_d;
    logic              pipe_busy, last_write;

    kw_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (ag_load),
        .load_addr (ADDR_W'(kw_start(cfg_f))),
        .inc       (ag_inc),
        .addr      (ag_addr),
        .idx       (ag_idx),
        .last      (ag_last)
    );

    // Config handshake: a config transfers on the edge where cfg_valid && cfg_ready;
    // cfg_ready is high only in IDLE, so offers while busy are never latched.
    always_comb begin
        state_d  = state_q;
        passes_d = passes_q;
        ag_load  = 1'b0;
        ag_inc   = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (cfg_valid) begin
                    ag_load  = 1'b1;
                    passes_d = cfg_passes;
                    state_d  = ST_LOAD;
                end
                ST_LOAD: begin
                    ag_inc = 1'b1;
                    if (ag_last) state_d = ST_DRAIN;
                end
                // With no passes, hold until the write pipe is empty so
                // layer_done never overlaps a weight write.
                ST_DRAIN: begin
                    if (passes_q == '0) begin
                        if (!pipe_busy) state_d = ST_DONE;
                    end else if (last_write) begin
                        state_d = ST_START;
                    end
                end
                ST_START: state_d = ST_WAIT;
                ST_WAIT: if (conv_done) begin
                    passes_d = passes_q - PASS_W'(1);
                    state_d  = (passes_q == PASS_W'(1)) ? ST_DONE : ST_START;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign rom_en     = (state_q == ST_LOAD);
    assign rom_addr   = rom_en ? ag_addr : '0;
    assign conv_start = (state_q == ST_START);
    assign layer_done = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign cfg_ready  = (state_q == ST_IDLE);
    assign dbg_state  = state_q;
    assign last_write = w_wr_en && (w_wr_idx == IDX_W'(WPK - 1));

    assign en1_d  = rom_en && !abort;
    assign idx1_d = ag_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            passes_q <= '0;
            en1_q    <= 1'b0;
            idx1_q   <= '0;
        end else begin
            state_q  <= state_d;
            passes_q <= passes_d;
            en1_q    <= en1_d;
            idx1_q   <= idx1_d;
        end
    end

`ifdef KW_ROM_REG_EN
    logic             en2_q, en2_d;
    logic [IDX_W-1:0] idx2_q, idx2_d;

    assign en2_d  = en1_q && !abort;
    assign idx2_d = idx1_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en2_q  <= 1'b0;
            idx2_q <= '0;
        end else begin
            en2_q  <= en2_d;
            idx2_q <= idx2_d;
        end
    end

    assign w_wr_en   = en2_q;
    assign w_wr_idx  = idx2_q;
    assign pipe_busy = en1_q || en2_q;
`else
    assign w_wr_en   = en1_q;
    assign w_wr_idx  = idx1_q;
    assign pipe_busy = en1_q;
`endif
endmodule

// File: tb/tb_conv_kw_sequencer.sv
// Directed bench for conv_kw_sequencer; read latency follows KW_ROM_REG_EN
// so the same vectors cover both ROM configurations.
module tb_conv_kw_sequencer;
    import conv_ctrl_pkg::*;

`ifdef KW_ROM_REG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [2:0] cfg_f = 3'd0;
    logic [3:0] cfg_passes = 4'd0;
    logic       abort = 1'b0;
    logic       rom_en;
    logic [6:0] rom_addr;
    logic       w_wr_en;
    logic [2:0] w_wr_idx;
    logic       conv_start;
    logic       conv_done = 1'b0;
    logic       layer_done;
    logic       busy;
    state_t     dbg_state;

    int checks = 0;
    int errors = 0;

    conv_kw_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_f      (cfg_f),
        .cfg_passes (cfg_passes),
        .abort      (abort),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .w_wr_en    (w_wr_en),
        .w_wr_idx   (w_wr_idx),
        .conv_start (conv_start),
        .conv_done  (conv_done),
        .layer_done (layer_done),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After this returns the sequencer is in cycle 1 (accept was edge 0).
    task automatic start_cfg(input logic [2:0] f, input logic [3:0] p);
        cfg_f      = f;
        cfg_passes = p;
        cfg_valid  = 1'b1;
        tick();
        cfg_valid  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0 || rom_en !== 1'b0 || rom_addr !== 7'd0 ||
            w_wr_en !== 1'b0 || w_wr_idx !== 3'd0 || conv_start !== 1'b0 || layer_done !== 1'b0)
            begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b busy=%b en=%b addr=%0d wr=%b idx=%0d cs=%b ld=%b, required 1 0 0 0 0 0 0 0",
                     cfg_ready, busy, rom_en, rom_addr, w_wr_en, w_wr_idx, conv_start, layer_done);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++;
        if (dbg_state !== ST_IDLE || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: state=%0d rdy=%b, required 0 1", dbg_state, cfg_ready);
        end
    endtask

    task automatic test_f2_one_pass();
        logic       exp_en, exp_wr;
        logic [6:0] exp_addr;
        logic [2:0] exp_idx;
        start_cfg(3'd2, 4'd1);
        for (int c = 1; c <= 9 + L; c++) begin
            exp_en   = (c <= 8);
            exp_addr = (c <= 8) ? 7'(16 + c) : 7'd0;
            exp_wr   = (c >= 1 + L) && (c <= 8 + L);
            exp_idx  = 3'(c - 1 - L);
            checks++;
            if (rom_en !== exp_en || rom_addr !== exp_addr) begin
                errors++;
                $display("FAIL f2_rom c=%0d: en=%b addr=%0d, required %b %0d", c, rom_en, rom_addr, exp_en, exp_addr);
            end
            checks++;
            if (w_wr_en !== exp_wr || (exp_wr && w_wr_idx !== exp_idx)) begin
                errors++;
                $display("FAIL f2_write c=%0d: wr=%b idx=%0d, required %b %0d", c, w_wr_en, w_wr_idx, exp_wr, exp_idx);
            end
            checks++;
            if (conv_start !== (c == 9 + L)) begin
                errors++;
                $display("FAIL f2_conv_start c=%0d: got %b, required %b", c, conv_start, (c == 9 + L));
            end
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (conv_start !== 1'b0 || layer_done !== 1'b0 || dbg_state !== ST_WAIT) begin
                errors++;
                $display("FAIL f2_wait: cs=%b ld=%b state=%0d, required 0 0 %0d", conv_start, layer_done, dbg_state, ST_WAIT);
            end
            tick();
        end
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        checks++;
        if (layer_done !== 1'b1) begin
            errors++;
            $display("FAIL f2_layer_done: got %b, required 1", layer_done);
        end
        tick();
        checks++;
        if (layer_done !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL f2_idle: ld=%b rdy=%b busy=%b, required 0 1 0", layer_done, cfg_ready, busy);
        end
    endtask

    task automatic test_f7_three_passes();
        int starts, dones, bad, wait_cnt, cyc;
        logic outstanding;
        starts = 0; dones = 0; bad = 0; wait_cnt = -1; outstanding = 1'b0;
        start_cfg(3'd7, 4'd3);
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (rom_en !== 1'b1 || rom_addr !== 7'(56 + c)) begin
                errors++;
                $display("FAIL f7_addr c=%0d: en=%b addr=%0d, required 1 %0d", c, rom_en, rom_addr, 56 + c);
            end
            tick();
        end
        for (cyc = 0; cyc < 100; cyc++) begin
            conv_done = 1'b0;
            if (conv_start) begin
                starts++;
                if (outstanding) bad++;
                outstanding = 1'b1;
                wait_cnt = 3;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    conv_done = 1'b1;
                    outstanding = 1'b0;
                end
            end
            if (layer_done) dones++;
            if (dones > 0 && !busy) break;
            tick();
        end
        conv_done = 1'b0;
        checks++;
        if (cyc >= 100) begin
            errors++;
            $display("FAIL f7_timeout: busy=%b after %0d cycles, required idle", busy, cyc);
        end
        checks++;
        if (starts !== 3 || bad !== 0) begin
            errors++;
            $display("FAIL f7_starts: starts=%0d unpaired=%0d, required 3 0", starts, bad);
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL f7_layer_done: count=%0d, required 1", dones);
        end
    endtask

    task automatic test_zero_passes();
        int wr_cnt, starts, done_cyc, idx_bad;
        wr_cnt = 0; starts = 0; done_cyc = -1; idx_bad = 0;
        start_cfg(3'd0, 4'd0);
        for (int c = 1; c <= 12; c++) begin
            checks++;
            if (rom_en !== (c <= 8) || rom_addr !== ((c <= 8) ? 7'(c) : 7'd0)) begin
                errors++;
                $display("FAIL zp_rom c=%0d: en=%b addr=%0d, required %b %0d", c, rom_en, rom_addr, (c <= 8), (c <= 8) ? c : 0);
            end
            if (w_wr_en) begin
                if (w_wr_idx !== 3'(wr_cnt)) idx_bad++;
                wr_cnt++;
            end
            if (conv_start) starts++;
            if (layer_done) done_cyc = c;
            tick();
        end
        checks++;
        if (wr_cnt !== 8 || idx_bad !== 0) begin
            errors++;
            $display("FAIL zp_writes: count=%0d bad_idx=%0d, required 8 0", wr_cnt, idx_bad);
        end
        checks++;
        if (starts !== 0) begin
            errors++;
            $display("FAIL zp_no_start: conv_start count=%0d, required 0", starts);
        end
        checks++;
        if (done_cyc !== 10 + L) begin
            errors++;
            $display("FAIL zp_layer_done_cycle: got %0d, required %0d", done_cyc, 10 + L);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL zp_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_abort();
        int wr_cnt, done_cnt;
        wr_cnt = 0; done_cnt = 0;
        start_cfg(3'd1, 4'd1);
        repeat (3) tick();
        checks++;
        if (rom_addr !== 7'd12) begin
            errors++;
            $display("FAIL abort_pre_addr: got %0d, required 12", rom_addr);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (dbg_state !== ST_IDLE || rom_en !== 1'b0 || cfg_ready !== 1'b1 || conv_start !== 1'b0 ||
            w_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: state=%0d en=%b rdy=%b cs=%b wr=%b, required 0 0 1 0 0",
                     dbg_state, rom_en, cfg_ready, conv_start, w_wr_en);
        end
        for (int c = 0; c < 4; c++) begin
            if (w_wr_en) wr_cnt++;
            tick();
        end
        checks++;
        if (wr_cnt !== 0) begin
            errors++;
            $display("FAIL abort_writes_dropped: writes=%0d, required 0", wr_cnt);
        end
        start_cfg(3'd3, 4'd1);
        for (int c = 1; c <= 9 + L; c++) begin
            checks++;
            if (rom_addr !== ((c <= 8) ? 7'(24 + c) : 7'd0) || conv_start !== (c == 9 + L)) begin
                errors++;
                $display("FAIL abort_rerun c=%0d: addr=%0d cs=%b, required %0d %b",
                         c, rom_addr, conv_start, (c <= 8) ? 24 + c : 0, (c == 9 + L));
            end
            tick();
        end
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        checks++;
        if (layer_done !== 1'b1) begin
            errors++;
            $display("FAIL abort_rerun_done: got %b, required 1", layer_done);
        end
        tick();
        // abort and conv_done together in WAIT
        start_cfg(3'd0, 4'd1);
        repeat (9 + L) tick();
        checks++;
        if (dbg_state !== ST_WAIT) begin
            errors++;
            $display("FAIL abort_wait_reach: state=%0d, required %0d", dbg_state, ST_WAIT);
        end
        abort = 1'b1;
        conv_done = 1'b1;
        tick();
        abort = 1'b0;
        conv_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (layer_done) done_cnt++;
            tick();
        end
        checks++;
        if (done_cnt !== 0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL abort_wins: layer_done=%0d state=%0d, required 0 0", done_cnt, dbg_state);
        end
    endtask

    task automatic test_spurious();
        start_cfg(3'd4, 4'd1);
        tick();
        tick();
        conv_done  = 1'b1;
        cfg_valid  = 1'b1;
        cfg_f      = 3'd6;
        cfg_passes = 4'd9;
        tick();
        conv_done = 1'b0;
        cfg_valid = 1'b0;
        checks++;
        if (dbg_state !== ST_LOAD || rom_addr !== 7'd36) begin
            errors++;
            $display("FAIL spur_load: state=%0d addr=%0d, required %0d 36", dbg_state, rom_addr, ST_LOAD);
        end
        repeat (4) tick();
        checks++;
        if (rom_addr !== 7'd40) begin
            errors++;
            $display("FAIL spur_bank_kept: addr=%0d, required 40", rom_addr);
        end
        repeat (1 + L) tick();
        checks++;
        if (conv_start !== 1'b1) begin
            errors++;
            $display("FAIL spur_conv_start: got %b, required 1", conv_start);
        end
        tick();
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        checks++;
        if (layer_done !== 1'b1) begin
            errors++;
            $display("FAIL spur_passes_kept: layer_done=%b, required 1", layer_done);
        end
        tick();
    endtask

    task automatic test_async_reset();
        int done_cyc;
        done_cyc = -1;
        start_cfg(3'd5, 4'd2);
        repeat (9 + L) tick();
        checks++;
        if (dbg_state !== ST_WAIT) begin
            errors++;
            $display("FAIL ar_reach_wait: state=%0d, required %0d", dbg_state, ST_WAIT);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (dbg_state !== ST_IDLE || cfg_ready !== 1'b1 || busy !== 1'b0 || rom_en !== 1'b0 ||
            rom_addr !== 7'd0 || w_wr_en !== 1'b0 || w_wr_idx !== 3'd0 || conv_start !== 1'b0 ||
            layer_done !== 1'b0) begin
            errors++;
            $display("FAIL ar_outputs: state=%0d rdy=%b busy=%b en=%b addr=%0d wr=%b idx=%0d cs=%b ld=%b, required reset values",
                     dbg_state, cfg_ready, busy, rom_en, rom_addr, w_wr_en, w_wr_idx, conv_start, layer_done);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        start_cfg(3'd1, 4'd0);
        for (int c = 1; c <= 11 + L; c++) begin
            checks++;
            if (w_wr_en !== ((c >= 1 + L) && (c <= 8 + L))) begin
                errors++;
                $display("FAIL ar_write_latency c=%0d: wr=%b, required %b", c, w_wr_en, ((c >= 1 + L) && (c <= 8 + L)));
            end
            if (layer_done) done_cyc = c;
            tick();
        end
        checks++;
        if (done_cyc !== 10 + L) begin
            errors++;
            $display("FAIL ar_layer_done_cycle: got %0d, required %0d", done_cyc, 10 + L);
        end
    endtask

    initial begin
        test_reset();
        test_f2_one_pass();
        test_f7_three_passes();
        test_zero_passes();
        test_abort();
        test_spurious();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
